// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate-extension mode encodings.
package cpu_pkg;

  localparam int unsigned EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SEXT = 2'd0,  // sign-extend
    EXT_ZEXT = 2'd1,  // zero-extend
    EXT_LUI  = 2'd2,  // place in upper bits, zero-fill below
    EXT_BOFS = 2'd3   // sign-extend then shift left by 2 (branch offset)
  } ext_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender, IN_W -> OUT_W, mode-selected.
// Ports:
//   imm   - raw immediate
//   mode  - extension mode (cpu_pkg::ext_mode_e encoding)
//   ext_c - extended value (combinational)
module imm_ext_core
  import cpu_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [OUT_W-1:0]      ext_c
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_c;

  assign sext_c = {{PAD_W{imm[IN_W-1]}}, imm};

  // Mode select; BOFS drops the top two bits of the sign-extended value.
  always_comb begin
    ext_c = sext_c;
    case (ext_mode_e'(mode))
      EXT_SEXT: ext_c = sext_c;
      EXT_ZEXT: ext_c = {PAD_W'(0), imm};
      EXT_LUI:  ext_c = {imm, PAD_W'(0)};
      EXT_BOFS: ext_c = {sext_c[OUT_W-3:0], 2'b00};
      default:  ext_c = sext_c;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready handshake and a two-entry
// skid buffer (main drives outputs, skid absorbs one beat of back-pressure).
// Ports:
//   clk, rst (async, active-high), flush (sync discard of buffered entries)
//   in_valid/in_ready/in_imm/in_mode/in_tag   - upstream handshake
//   out_valid/out_ready/out_imm/out_tag       - downstream handshake
module imm_ext_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_imm,
  output logic [TAG_W-1:0]      out_tag
);

  // BOFS needs two headroom bits above the sign-extended immediate.
  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be >= IN_W + 2");
    end
  endgenerate

  logic [OUT_W-1:0] ext_c;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext_c(ext_c)
  );

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] main_imm_q,   main_imm_d;
  logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic accept_c;
  logic emit_c;

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_tag   = main_tag_q;

  assign accept_c = in_valid & ~skid_valid_q;
  assign emit_c   = main_valid_q & out_ready;

  // Next-state: skid refills main on emit; new data goes to main if it is
  // free this cycle, otherwise to skid. Flush clears occupancy only.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (emit_c) begin
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      if (!main_valid_q || emit_c) begin
        main_valid_d = 1'b1;
        main_imm_d   = ext_c;
        main_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = ext_c;
        skid_tag_d   = in_tag;
      end
    end else if (emit_c) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed steps plus a randomised
// phase, all checked against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  // Narrow instance for the 8->16 width checks.
  logic        in8_valid;
  logic        in8_ready;
  logic [7:0]  in8_imm;
  logic [1:0]  in8_mode;
  logic [4:0]  in8_tag;
  logic        out8_valid;
  logic [15:0] out8_imm;
  logic [4:0]  out8_tag;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_imm[$];
  logic [4:0]  q_tag[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_imm(in8_imm),
    .in_mode(in8_mode), .in_tag(in8_tag),
    .out_valid(out8_valid), .out_ready(1'b1),
    .out_imm(out8_imm), .out_tag(out8_tag)
  );

  // Reference extension from the arithmetic meaning of each mode.
  function automatic logic [31:0] ext_ref(input int in_w, input int out_w,
                                          input logic [31:0] imm,
                                          input logic [1:0] mode);
    longint u, s, mask, r;
    u    = longint'(imm) & ((64'sd1 << in_w) - 1);
    s    = (u >= (64'sd1 << (in_w - 1))) ? u - (64'sd1 << in_w) : u;
    mask = (64'sd1 << out_w) - 1;
    case (mode)
      2'd0:    r = s & mask;
      2'd1:    r = u;
      2'd2:    r = (u * (64'sd1 << (out_w - in_w))) & mask;
      default: r = (s * 4) & mask;
    endcase
    return 32'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q_imm.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q_imm.size() > 0));
    if (q_imm.size() > 0) begin
      chk({tag, ".out_imm"}, out_imm, q_imm[0]);
      chk({tag, ".out_tag"}, 32'(out_tag), 32'(q_tag[0]));
    end
  endtask

  // One clock cycle: drive, advance model, clock, check on falling edge.
  task automatic step(input string tag, input logic iv, input logic [15:0] imm,
                      input logic [1:0] mode, input logic [4:0] tg,
                      input logic ordy, input logic fl);
    logic acc, emit;
    in_valid  = iv;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    acc  = iv && (q_imm.size() < 2);
    emit = ordy && (q_imm.size() > 0);
    if (fl) begin
      q_imm.delete();
      q_tag.delete();
    end else begin
      if (emit) begin
        void'(q_imm.pop_front());
        void'(q_tag.pop_front());
      end
      if (acc) begin
        q_imm.push_back(ext_ref(16, 32, 32'(imm), mode));
        q_tag.push_back(tg);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic step8(input string tag, input logic [7:0] imm,
                       input logic [1:0] mode, input logic [15:0] lit);
    in8_valid = 1'b1;
    in8_imm   = imm;
    in8_mode  = mode;
    in8_tag   = 5'd9;
    @(posedge clk);
    @(negedge clk);
    in8_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out8_valid), 32'd1);
    chk({tag, ".lit"},   32'(out8_imm),   32'(lit));
    chk({tag, ".model"}, 32'(out8_imm),   ext_ref(8, 16, 32'(imm), mode));
    chk({tag, ".tag"},   32'(out8_tag),   32'd9);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0;
    in_tag = '0; out_ready = 1'b0;
    in8_valid = 1'b0; in8_imm = '0; in8_mode = '0; in8_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_imm",   out_imm,        32'd0);
    chk("rst.out_tag",   32'(out_tag),   32'd0);
    rst = 1'b0;

    // Streaming, one per cycle, latency 1.
    step("s0", 1'b1, 16'h8000, 2'd0, 5'd1, 1'b1, 1'b0);
    chk("s0.lit", out_imm, 32'hFFFF8000);
    step("s1", 1'b1, 16'h8000, 2'd1, 5'd2, 1'b1, 1'b0);
    chk("s1.lit", out_imm, 32'h00008000);
    step("s2", 1'b1, 16'h1234, 2'd2, 5'd3, 1'b1, 1'b0);
    chk("s2.lit", out_imm, 32'h12340000);
    step("s3", 1'b1, 16'hFFFF, 2'd3, 5'd4, 1'b1, 1'b0);
    chk("s3.lit", out_imm, 32'hFFFFFFFC);
    chk("s3.tag", 32'(out_tag), 32'd4);
    step("s4", 1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

    // Back-pressure: two accepted, third held off, then drain in order.
    step("bp0", 1'b1, 16'h0011, 2'd1, 5'd10, 1'b0, 1'b0);
    step("bp1", 1'b1, 16'h0022, 2'd1, 5'd11, 1'b0, 1'b0);
    chk("bp1.in_ready_low", 32'(in_ready), 32'd0);
    step("bp2", 1'b1, 16'h0033, 2'd1, 5'd12, 1'b0, 1'b0);
    chk("bp2.head", out_imm, 32'h00000011);
    step("bp3", 1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    chk("bp3.second", out_imm, 32'h00000022);
    step("bp4", 1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    chk("bp4.in_ready_high", 32'(in_ready), 32'd1);

    // Flush with both entries full and an input offered the same cycle.
    step("fl0", 1'b1, 16'h00AA, 2'd0, 5'd20, 1'b0, 1'b0);
    step("fl1", 1'b1, 16'h00BB, 2'd0, 5'd21, 1'b0, 1'b0);
    step("fl2", 1'b1, 16'h00CC, 2'd0, 5'd22, 1'b0, 1'b1);
    chk("fl2.out_valid", 32'(out_valid), 32'd0);
    chk("fl2.in_ready",  32'(in_ready),  32'd1);
    step("fl3", 1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

    // Async reset in the middle of a stall, between clock edges.
    step("ar0", 1'b1, 16'h0101, 2'd0, 5'd5, 1'b0, 1'b0);
    step("ar1", 1'b1, 16'h0202, 2'd0, 5'd6, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready",  32'(in_ready),  32'd1);
    chk("ar.out_imm",   out_imm,        32'd0);
    q_imm.delete();
    q_tag.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    step("ar2", 1'b1, 16'hF00F, 2'd3, 5'd7, 1'b1, 1'b0);

    // Narrow configuration.
    step8("w8.sext", 8'h80, 2'd0, 16'hFF80);
    step8("w8.lui",  8'hAB, 2'd2, 16'hAB00);
    step8("w8.bofs", 8'hC0, 2'd3, 16'hFF00);

    // Randomised traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step("rnd", $urandom_range(0, 3) != 0, 16'($urandom),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
